// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming definitions for the encoder engine and the decoder.
// Contents: FSM state type, codeword parity-bit positions, and the
// 11-bit message to 16-bit codeword encode function.
// Codeword layout (bit15 first): {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
package hamming_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CW_W   = 16;

    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P2 = 2;
    localparam int unsigned P4 = 4;
    localparam int unsigned P8 = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        ENC   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Data bits fill the non-power-of-two positions; p0 makes the word even parity.
    function automatic logic [CW_W-1:0] hamming_encode(input logic [11:1] d);
        logic [CW_W-1:0] cw;
        cw        = '0;
        cw[15:9]  = d[11:5];
        cw[7:5]   = d[4:2];
        cw[3]     = d[1];
        cw[P8]    = ^d[11:5];
        cw[P4]    = (^d[11:8]) ^ (^d[4:2]);
        cw[P2]    = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        cw[P1]    = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        cw[P0]    = ^cw[15:1];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_secded_enc.sv
// Purely combinational 11-bit message to 16-bit SECDED codeword encoder.
// Ports:
//   data  - message bits d[11:1] packed as data[10:0]
//   cw_c  - combinational codeword
module hamming_secded_enc
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   cw_c
);

    assign cw_c = hamming_encode(data);

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-mapped SECDED Hamming encoder engine.
// On an accepted start, reads NUM_MSG two-byte messages from SRC_BASE,
// encodes each into a 16-bit codeword and writes it as two bytes at
// DST_BASE, then raises done (held until the next accepted start or reset).
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   start          - request, sampled in IDLE only
//   done           - all codewords written
//   mem_addr       - byte address
//   mem_rd_en      - read strobe; mem_rdata valid the following cycle
//   mem_rdata      - read data
//   mem_wr_en      - write strobe; memory writes mem_wdata on the same edge
//   mem_wdata      - write data
//   cycle_cnt      - busy-cycle counter (only with HAMMING_ENC_PERF_EN defined)
// Optional feature macro: HAMMING_ENC_PERF_EN
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned AW       = 8
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata
`ifdef HAMMING_ENC_PERF_EN
    ,
    output logic [15:0]   cycle_cnt
`endif
);

    localparam int unsigned   IW       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

    state_t          state;
    logic [IW-1:0]   msg_idx;
    logic [7:0]      lo_q;
    logic [7:0]      cw_hi_q;
    logic [CW_W-1:0] enc_cw_c;

    function automatic logic [AW-1:0] byte_addr(input int unsigned base,
                                                 input int unsigned idx,
                                                 input int unsigned ofs);
        return AW'(base + 2 * idx + ofs);
    endfunction

    // Encoder sees the captured low byte plus the high byte arriving this cycle.
    hamming_secded_enc u_enc (
        .data ({mem_rdata[2:0], lo_q}),
        .cw_c (enc_cw_c)
    );

    // Control FSM; memory strobes are registered so they are visible during the
    // state that owns them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            msg_idx   <= '0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lo_q      <= '0;
            cw_hi_q   <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RD_LO;
                        msg_idx   <= '0;
                        done      <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= byte_addr(SRC_BASE, 0, 0);
                    end
                end
                RD_LO: begin
                    state     <= RD_HI;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= byte_addr(SRC_BASE, 32'(msg_idx), 1);
                end
                RD_HI: begin
                    lo_q  <= mem_rdata;
                    state <= ENC;
                end
                ENC: begin
                    cw_hi_q   <= enc_cw_c[15:8];
                    state     <= WR_LO;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= byte_addr(DST_BASE, 32'(msg_idx), 0);
                    mem_wdata <= enc_cw_c[7:0];
                end
                WR_LO: begin
                    state     <= WR_HI;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= byte_addr(DST_BASE, 32'(msg_idx), 1);
                    mem_wdata <= cw_hi_q;
                end
                WR_HI: begin
                    if (msg_idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        msg_idx   <= msg_idx + IW'(1);
                        state     <= RD_LO;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= byte_addr(SRC_BASE, 32'(msg_idx) + 1, 0);
                    end
                end
                DONE: begin
                    // Holding start keeps us here so a held request cannot rerun.
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HAMMING_ENC_PERF_EN
    // Busy-cycle counter, saturating; frozen in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                cycle_cnt <= '0;
            end
        end else if (state != DONE) begin
            if (cycle_cnt != 16'hFFFF) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Self-checking bench for hamming_enc_engine: byte memory model, positional
// Hamming reference, per-cycle strobe checker against expected read/write queues.
module tb_hamming_enc_engine;

    localparam int unsigned NUM_MSG  = 15;
    localparam int unsigned SRC_BASE = 0;
    localparam int unsigned DST_BASE = 30;
    localparam int unsigned AW       = 8;
    localparam logic [7:0]  SENT     = 8'h5A;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata = '0;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
`ifdef HAMMING_ENC_PERF_EN
    logic [15:0]   cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] src_copy [2*NUM_MSG];

    logic [AW-1:0] exp_rd_addr [$];
    logic [AW-1:0] exp_wr_addr [$];
    logic [7:0]    exp_wr_data [$];

    hamming_enc_engine #(
        .NUM_MSG  (NUM_MSG),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE),
        .AW       (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
`ifdef HAMMING_ENC_PERF_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Byte memory: registered read, write on the strobe edge.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Textbook Hamming(15,11): data in non-power-of-two positions, parity pk
    // covers every position with bit k set, then overall even parity in bit 0.
    function automatic logic [15:0] ref_encode(input logic [10:0] m);
        logic [15:0] cw;
        int k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = m[k];
                k++;
            end
        end
        for (int p = 0; p < 4; p++) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if (((pos >> p) & 1) == 1) par ^= cw[pos];
            end
            cw[1 << p] = par;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] msg_of(input int i);
        logic [7:0] hi;
        hi = mem[SRC_BASE + 2*i + 1];
        return {hi[2:0], mem[SRC_BASE + 2*i]};
    endfunction

    // Every strobe cycle is checked against the expected transaction queues.
    always @(negedge clk) begin : compare
        logic [AW-1:0] a;
        logic [7:0]    d;
        if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1)
            check("rd_wr_overlap", 32'(mem_rd_en & mem_wr_en), 32'd0);
        if (mem_rd_en === 1'b1) begin
            check("rd_expected", 32'(exp_rd_addr.size() != 0), 32'd1);
            if (exp_rd_addr.size() != 0) begin
                a = exp_rd_addr.pop_front();
                check("rd_addr", 32'(mem_addr), 32'(a));
            end
        end
        if (mem_wr_en === 1'b1) begin
            check("wr_expected", 32'(exp_wr_addr.size() != 0), 32'd1);
            if (exp_wr_addr.size() != 0) begin
                a = exp_wr_addr.pop_front();
                d = exp_wr_data.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(a));
                check("wr_data", 32'(mem_wdata), 32'(d));
            end
        end
    end

    task automatic flush_model();
        exp_rd_addr.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
    endtask

    task automatic build_model();
        logic [15:0] cw;
        flush_model();
        for (int i = 0; i < int'(NUM_MSG); i++) begin
            cw = ref_encode(msg_of(i));
            exp_rd_addr.push_back(AW'(SRC_BASE + 2*i));
            exp_rd_addr.push_back(AW'(SRC_BASE + 2*i + 1));
            exp_wr_addr.push_back(AW'(DST_BASE + 2*i));
            exp_wr_data.push_back(cw[7:0]);
            exp_wr_addr.push_back(AW'(DST_BASE + 2*i + 1));
            exp_wr_data.push_back(cw[15:8]);
        end
    endtask

    // Loads 15 messages (first four directed when requested) and fills the
    // destination with a sentinel.
    task automatic load_msgs(input bit directed);
        logic [7:0] lo, hi;
        for (int i = 0; i < int'(NUM_MSG); i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            if (directed) begin
                case (i)
                    0: begin lo = 8'h00; hi = 8'h00; end
                    1: begin lo = 8'hFF; hi = 8'hFF; end
                    2: begin lo = 8'h01; hi = 8'h00; end
                    3: begin lo = 8'h00; hi = 8'h04; end
                    default: ;
                endcase
            end
            mem[SRC_BASE + 2*i]     <= lo;
            mem[SRC_BASE + 2*i + 1] <= hi;
            src_copy[2*i]           = lo;
            src_copy[2*i + 1]       = hi;
        end
        for (int i = 0; i < int'(2*NUM_MSG); i++) mem[DST_BASE + i] <= SENT;
        #1;
    endtask

    // Starts a run, optionally pulses start again mid-run, checks done latency,
    // results, and that a held start does not rerun.
    task automatic run_and_check(input int glitch_at);
        int n;
        logic [15:0] cw;
        build_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check("done_cleared_on_start", 32'(done), 32'd0);
        while (done !== 1'b1 && n < 200) begin
            start = (n == glitch_at);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_latency", 32'(n), 32'(5*NUM_MSG + 1));
`ifdef HAMMING_ENC_PERF_EN
        check("cycle_cnt_done", 32'(cycle_cnt), 32'(5*NUM_MSG));
`endif
        for (int i = 0; i < int'(NUM_MSG); i++) begin
            cw = ref_encode(msg_of(i));
            check("out_lo", 32'(mem[DST_BASE + 2*i]), 32'(cw[7:0]));
            check("out_hi", 32'(mem[DST_BASE + 2*i + 1]), 32'(cw[15:8]));
        end
        for (int i = 0; i < int'(2*NUM_MSG); i++)
            check("src_intact", 32'(mem[SRC_BASE + i]), 32'(src_copy[i]));
        check("rd_queue_drained", 32'(exp_rd_addr.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr_addr.size()), 32'd0);
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("held_start_no_rd", 32'(mem_rd_en), 32'd0);
        end
        check("done_held_start", 32'(done), 32'd1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_in_idle", 32'(done), 32'd1);
        check("idle_no_rd", 32'(mem_rd_en), 32'd0);
    endtask

    initial begin : main
        logic [15:0] cw;
        bit found;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef HAMMING_ENC_PERF_EN
        check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
        reset = 1'b1;

        check("ref_000", 32'(ref_encode(11'h000)), 32'h0000);
        check("ref_7ff", 32'(ref_encode(11'h7FF)), 32'hFFFF);
        check("ref_001", 32'(ref_encode(11'h001)), 32'h000F);
        check("ref_400", 32'(ref_encode(11'h400)), 32'h8117);

        // Directed messages plus random fill.
        load_msgs(1'b1);
        run_and_check(0);
        check("lit_b30", 32'(mem[30]), 32'h00);
        check("lit_b31", 32'(mem[31]), 32'h00);
        check("lit_b32", 32'(mem[32]), 32'hFF);
        check("lit_b33", 32'(mem[33]), 32'hFF);
        check("lit_b34", 32'(mem[34]), 32'h0F);
        check("lit_b35", 32'(mem[35]), 32'h00);
        check("lit_b36", 32'(mem[36]), 32'h17);
        check("lit_b37", 32'(mem[37]), 32'h81);

        // Fully random messages with a spurious mid-run start pulse.
        load_msgs(1'b0);
        run_and_check(20);

        // Reset during WR_LO of message 7 aborts; only byte 44 lands.
        load_msgs(1'b0);
        build_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (mem_wr_en === 1'b1 && mem_addr == AW'(DST_BASE + 14)) found = 1'b1;
        end
        check("reach_wr_lo_msg7", 32'(found), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        flush_model();
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wdata", 32'(mem_wdata), 32'd0);
`ifdef HAMMING_ENC_PERF_EN
        check("abort_cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle_rd", 32'(mem_rd_en), 32'd0);
        check("abort_stays_idle_wr", 32'(mem_wr_en), 32'd0);
        cw = ref_encode(msg_of(7));
        check("abort_b44_written", 32'(mem[44]), 32'(cw[7:0]));
        for (int i = 45; i < 60; i++)
            check("abort_unwritten", 32'(mem[i]), 32'(SENT));

        // Restart after the abort completes normally.
        run_and_check(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
